// File: rtl/unified_mem_arbiter.sv
// Shares one variable-latency memory between fetch and data; rdy pulses 2+ cycles after the request is seen.
// Requesters are held by level until their rdy pulse; data/fetch alternate under contention; hlt stalls grants.
module unified_mem_arbiter #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_rdy,
  output logic [DATA_W-1:0] if_data,
  input  logic              d_rd,
  input  logic              d_wr,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wrData,
  output logic              d_rdy,
  output logic [DATA_W-1:0] d_rdData,
  input  logic              flush,
  input  logic              hlt,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              err
);

  typedef enum logic [1:0] {IDLE, FETCH, DATA} state_t;

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_t      state;
  logic        last_d;
  logic        drop_if;
  logic [7:0]  tcnt;

  logic        if_elig;
  logic        d_elig;
  logic        fetch_ok;
  logic        grant_d;
  logic        grant_f;
  logic        tmo;
  logic        done;
  logic [DATA_W-1:0] rd_val;

  // A requester whose rdy is high this cycle is still holding the old level.
  always_comb begin
    if_elig  = if_req && !if_rdy;
    d_elig   = (d_rd || d_wr) && !d_rdy;
    fetch_ok = if_elig && !flush;
    grant_d  = (state == IDLE) && !hlt && d_elig && (!fetch_ok || !last_d);
    grant_f  = (state == IDLE) && !hlt && fetch_ok && !grant_d;
    tmo      = !mem_ack && (tcnt == TMO_LAST);
    done     = (state != IDLE) && (mem_ack || tmo);
    rd_val   = tmo ? {DATA_W{1'b1}} : mem_rdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      last_d    <= 1'b0;
      drop_if   <= 1'b0;
      tcnt      <= '0;
      if_rdy    <= 1'b0;
      if_data   <= '0;
      d_rdy     <= 1'b0;
      d_rdData  <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      err       <= 1'b0;
    end else begin
      if_rdy <= 1'b0;
      d_rdy  <= 1'b0;
      case (state)
        IDLE: begin
          tcnt <= '0;
          if (grant_d) begin
            state     <= DATA;
            last_d    <= 1'b1;
            mem_en    <= 1'b1;
            mem_we    <= d_wr;
            mem_addr  <= d_addr;
            mem_wdata <= d_wrData;
          end else if (grant_f) begin
            state     <= FETCH;
            last_d    <= 1'b0;
            mem_en    <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= if_addr;
            mem_wdata <= '0;
          end
        end
        FETCH: begin
          if (done) begin
            state   <= IDLE;
            mem_en  <= 1'b0;
            mem_we  <= 1'b0;
            tcnt    <= '0;
            drop_if <= 1'b0;
            if (tmo) err <= 1'b1;
            // A flush landing on the completion cycle still kills the fetch.
            if (!(drop_if || flush)) begin
              if_rdy  <= 1'b1;
              if_data <= rd_val;
            end
          end else begin
            tcnt <= tcnt + 8'd1;
            if (flush) drop_if <= 1'b1;
          end
        end
        DATA: begin
          if (done) begin
            state  <= IDLE;
            mem_en <= 1'b0;
            mem_we <= 1'b0;
            tcnt   <= '0;
            d_rdy  <= 1'b1;
            if (tmo) err <= 1'b1;
            if (!mem_we) d_rdData <= rd_val;
          end else begin
            tcnt <= tcnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Randomized bench for unified_mem_arbiter against a transaction-level model.
module tb_unified_mem_arbiter;
  localparam int AW  = 16;
  localparam int DW  = 16;
  localparam int TMO = 15;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          if_req, if_rdy, d_rd, d_wr, d_rdy, flush, hlt;
  logic [AW-1:0] if_addr, d_addr, mem_addr;
  logic [DW-1:0] if_data, d_wrData, d_rdData, mem_wdata, mem_rdata;
  logic          mem_en, mem_we, mem_ack, err;

  int n_checks = 0;
  int n_errors = 0;

  // Transaction-level reference state.
  logic [DW-1:0] m_if_data, m_d_rdData;
  bit            m_err, m_last_d;

  unified_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_rdy(if_rdy), .if_data(if_data),
    .d_rd(d_rd), .d_wr(d_wr), .d_addr(d_addr), .d_wrData(d_wrData),
    .d_rdy(d_rdy), .d_rdData(d_rdData),
    .flush(flush), .hlt(hlt),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_if_data  = '0;
    m_d_rdData = '0;
    m_err      = 1'b0;
    m_last_d   = 1'b0;
  endtask

  task automatic run_single(input bit is_f, input bit rd, input bit wr,
                            input logic [AW-1:0] addr, input logic [DW-1:0] wdat,
                            input logic [DW-1:0] rdat, input int dly,
                            input int fl_at, input bit hmid);
    int   lat, en_cnt, exp_cyc;
    bit   is_wr, drop, wobble;
    is_wr = !is_f && wr;
    @(negedge clk);
    if (is_f) begin
      if_req = 1'b1; if_addr = addr;
    end else begin
      d_rd = rd; d_wr = wr; d_addr = addr; d_wrData = wdat;
    end
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!mem_en && lat < 20);
    chk("grant_lat", lat, 1);
    chk("mem_addr", mem_addr, addr);
    chk("mem_we", mem_we, is_wr);
    if (is_wr) chk("mem_wdata", mem_wdata, wdat);
    m_last_d = !is_f;
    if (hmid) hlt = 1'b1;
    en_cnt = 0;
    wobble = 1'b0;
    while (mem_en && en_cnt < 300) begin
      if (mem_addr !== addr || mem_we !== is_wr || (is_wr && mem_wdata !== wdat)) wobble = 1'b1;
      mem_ack   = (en_cnt == dly);
      mem_rdata = mem_ack ? rdat : DW'($urandom);
      flush     = (en_cnt == fl_at);
      @(negedge clk);
      en_cnt++;
    end
    mem_ack = 1'b0; flush = 1'b0; hlt = 1'b0;
    if_req = 1'b0; d_rd = 1'b0; d_wr = 1'b0;
    exp_cyc = (dly < TMO) ? dly + 1 : TMO;
    drop    = is_f && fl_at >= 0 && fl_at < exp_cyc;
    if (dly >= TMO) m_err = 1'b1;
    if (is_f && !drop) m_if_data = (dly < TMO) ? rdat : '1;
    if (!is_f && !is_wr) m_d_rdData = (dly < TMO) ? rdat : '1;
    chk("hold_stable", wobble, 0);
    chk("en_cycles", en_cnt, exp_cyc);
    chk("if_rdy", if_rdy, is_f && !drop);
    chk("d_rdy", d_rdy, !is_f);
    chk("if_data", if_data, m_if_data);
    chk("d_rdData", d_rdData, m_d_rdData);
    chk("err", err, m_err);
    @(negedge clk);
    chk("rdy_pulse", {if_rdy, d_rdy}, 0);
    chk("idle_after", mem_en, 0);
  endtask

  task automatic run_contention(input int ngrants);
    bit            first_d, exp_d, pend, cur_d;
    int            g, cyc, en_cnt, dly;
    logic [DW-1:0] rd;
    @(negedge clk);
    if_req = 1'b1; if_addr = 16'h0100;
    d_rd   = 1'b1; d_addr  = 16'h0040;
    first_d = !m_last_d;
    g = 0; cyc = 0; en_cnt = 0; pend = 0; cur_d = 0; dly = 0; rd = '0;
    while (g < ngrants && cyc < 500) begin
      @(negedge clk);
      cyc++;
      if (mem_en) begin
        if (en_cnt == 0) begin
          exp_d = first_d ^ g[0];
          cur_d = exp_d;
          chk("arb_order", mem_addr, exp_d ? 32'h0040 : 32'h0100);
          dly = $urandom_range(0, 3);
          rd  = DW'($urandom);
        end
        mem_ack   = (en_cnt == dly);
        mem_rdata = mem_ack ? rd : DW'($urandom);
        en_cnt++;
        if (mem_ack) begin
          g++;
          en_cnt   = 0;
          pend     = 1;
          m_last_d = cur_d;
          if (cur_d) m_d_rdData = rd; else m_if_data = rd;
        end
      end else begin
        mem_ack = 1'b0;
        if (pend) begin
          chk("ctn_rdy", {if_rdy, d_rdy}, cur_d ? 2'b01 : 2'b10);
          pend = 0;
        end
      end
    end
    chk("ctn_done", g, ngrants);
    @(negedge clk);
    mem_ack = 1'b0;
    if_req = 1'b0; d_rd = 1'b0;
    chk("ctn_last_rdy", {if_rdy, d_rdy}, cur_d ? 2'b01 : 2'b10);
    chk("ctn_if_data", if_data, m_if_data);
    chk("ctn_d_rdData", d_rdData, m_d_rdData);
    @(negedge clk);
    chk("ctn_idle", mem_en, 0);
  endtask

  initial begin
    bit        is_f, hold_bad;
    int        rw, r, dly, fl;
    rst_n = 1'b0;
    if_req = 0; if_addr = '0; d_rd = 0; d_wr = 0; d_addr = '0; d_wrData = '0;
    flush = 0; hlt = 0; mem_rdata = '0; mem_ack = 0;
    model_reset();
    #2;
    chk("reset_outs", {mem_en, mem_we, if_rdy, d_rdy, err, mem_addr}, 0);
    chk("reset_data", {if_data, d_rdData, mem_wdata}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run_single(1, 0, 0, 16'h0010, '0, 16'hB123, 2, -1, 0);
    run_contention(6);
    run_single(0, 0, 1, 16'h0022, 16'h5A5A, 16'h9999, 1, -1, 0);
    run_single(1, 0, 0, 16'h0008, '0, 16'h1234, 4, 1, 0);
    run_single(1, 0, 0, 16'h0030, '0, 16'h4321, 0, -1, 0);

    // hlt blocks grants; a stray ack while idle is ignored
    @(negedge clk);
    hlt = 1'b1; if_req = 1'b1; if_addr = 16'h0050;
    hold_bad = 0;
    for (int i = 0; i < 8; i++) begin
      mem_ack = (i == 3);
      @(negedge clk);
      if (mem_en || if_rdy || d_rdy) hold_bad = 1;
    end
    mem_ack = 1'b0;
    chk("hlt_no_grant", hold_bad, 0);
    hlt = 1'b0;
    @(negedge clk);
    chk("hlt_resume", mem_en, 1);
    chk("hlt_addr", mem_addr, 16'h0050);
    mem_ack = 1'b1; mem_rdata = 16'h7777;
    @(negedge clk);
    mem_ack = 1'b0; if_req = 1'b0;
    m_if_data = 16'h7777; m_last_d = 1'b0;
    chk("hlt_if_rdy", if_rdy, 1);
    chk("hlt_if_data", if_data, m_if_data);
    @(negedge clk);

    for (int t = 0; t < 40; t++) begin
      is_f = 1'($urandom_range(0, 1));
      rw   = $urandom_range(0, 2);
      r    = $urandom_range(0, 9);
      dly  = (r < 7) ? r : (r == 7) ? 13 : (r == 8) ? 14 : 255;
      fl   = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 6) : -1;
      run_single(is_f, rw != 1, rw != 0, AW'($urandom), DW'($urandom), DW'($urandom),
                 dly, fl, $urandom_range(0, 4) == 0);
    end

    run_single(0, 1, 0, 16'h0060, '0, 16'h0F0F, 255, -1, 0);
    repeat (5) @(negedge clk);
    chk("err_sticky", err, 1);

    // Reset while a data read is waiting on the memory
    d_rd = 1'b1; d_addr = 16'h0070;
    repeat (3) @(negedge clk);
    chk("pre_rst_en", mem_en, 1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_outs", {mem_en, mem_we, if_rdy, d_rdy, err, mem_addr}, 0);
    chk("rst_mid_data", {if_data, d_rdData, mem_wdata}, 0);
    d_rd = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_rst_idle", mem_en, 0);
    run_single(1, 0, 0, 16'h0080, '0, 16'hC0DE, 1, -1, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
endmodule
